// File: rtl/i3c_mode_scheduler_pkg.sv
// Shared state encoding, HDR constants and register-file special addresses
// for the I3C SDR/HDR-DDR mode scheduler.
package i3c_mode_scheduler_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_SDR_XFER,
      ST_ENTHDR,
      ST_HDR_DISPATCH,
      ST_CCC,
      ST_DDR,
      ST_HDR_RESTART,
      ST_HDR_EXIT,
      ST_DONE
   } state_t;

   localparam logic [2:0] HDR_DDR_MODE = 3'd6;
   localparam logic [7:0] ENTHDR_ADDR  = 8'h2E;
   localparam logic [7:0] CCC_ADDR     = 8'h30;
   localparam logic [7:0] DDR_ADDR     = 8'h31;
   localparam int         WD_WIDTH     = 10;

   function automatic logic [7:0] phase_addr(input state_t s);
      case (s)
         ST_ENTHDR: phase_addr = ENTHDR_ADDR;
         ST_CCC:    phase_addr = CCC_ADDR;
         ST_DDR:    phase_addr = DDR_ADDR;
         default:   phase_addr = 8'h00;
      endcase
   endfunction

endpackage

// File: rtl/i3c_mode_scheduler_watchdog.sv
// Per-phase watchdog: counts enabled cycles, cleared on every phase change,
// and flags expiry one count short of the limit.
module phase_watchdog #(
   parameter int WIDTH = 10
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_clear,
   input  logic             i_enable,
   input  logic [WIDTH-1:0] i_limit,
   output logic             o_expired
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable) begin
         r_count <= r_count + WIDTH'(1);
      end
   end

   // The count is stale from the previous phase until the clear lands.
   assign o_expired = !i_clear && (r_count == (i_limit - WIDTH'(1)));

endmodule

// File: rtl/i3c_mode_scheduler.sv
// I3C controller mode scheduler: arbitrates SDR/HDR requests and sequences
// the ENTHDR, CCC/DDR, restart and exit engines with a per-phase watchdog.
module i3c_mode_scheduler
   import i3c_mode_scheduler_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic       i_sdr_clk,
   input  logic       i_sdr_rst_n,
   input  logic       i_controller_en,
   input  logic       i_sdr_req,
   input  logic       i_hdr_req,
   input  logic       i_toc_interface,
   input  logic       i_cp_interface,
   input  logic [2:0] i_MODE_interface,
   input  logic       i_sdr_done,
   input  logic       i_enthdr_done,
   input  logic       i_ccc_done,
   input  logic       i_ddr_mode_done,
   input  logic       i_restart_done,
   input  logic       i_exit_done,
   output logic       o_sdr_enable,
   output logic       o_enthdr_enable,
   output logic       o_ccc_enable,
   output logic       o_ddrmode_enable,
   output logic       o_restart_enable,
   output logic       o_exit_enable,
   output logic [7:0] o_regf_address_special,
   output logic       o_busy,
   output logic       o_ctrl_done,
   output logic       o_error
);

   localparam logic [WD_WIDTH-1:0] LP_LIMIT = WD_WIDTH'(TIMEOUT_CYCLES);

   state_t r_state;
   state_t r_prev_state;
   state_t w_next;
   logic   r_hdr_prio;
   logic   r_err;
   logic   r_abort;
   logic   w_set_err;
   logic   w_set_abort;
   logic   w_expired;
   logic   w_any_enable;
   logic   w_state_change;
   logic   w_hdr_phase_done;

   assign w_any_enable = o_sdr_enable | o_enthdr_enable | o_ccc_enable |
                         o_ddrmode_enable | o_restart_enable | o_exit_enable;
   assign w_state_change   = (r_state != r_prev_state);
   assign w_hdr_phase_done = (r_state == ST_CCC) ? i_ccc_done : i_ddr_mode_done;

   phase_watchdog #(
      .WIDTH(WD_WIDTH)
   ) u_watchdog (
      .i_clk     (i_sdr_clk),
      .i_rst_n   (i_sdr_rst_n),
      .i_clear   (w_state_change),
      .i_enable  (w_any_enable),
      .i_limit   (LP_LIMIT),
      .o_expired (w_expired)
   );

   // Done inputs are checked before the watchdog so a completion always wins.
   always_comb begin
      w_next      = r_state;
      w_set_err   = 1'b0;
      w_set_abort = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_controller_en && (i_sdr_req || i_hdr_req)) begin
               if (i_sdr_req && (!i_hdr_req || !r_hdr_prio)) begin
                  w_next = ST_SDR_XFER;
               end else if (i_MODE_interface == HDR_DDR_MODE) begin
                  w_next = ST_ENTHDR;
               end else begin
                  w_next    = ST_DONE;
                  w_set_err = 1'b1;
               end
            end
         end
         ST_SDR_XFER: begin
            if (i_sdr_done) begin
               w_next = ST_DONE;
            end else if (w_expired) begin
               w_next    = ST_DONE;
               w_set_err = 1'b1;
            end
         end
         ST_ENTHDR: begin
            if (i_enthdr_done) begin
               w_next = ST_HDR_DISPATCH;
            end else if (w_expired) begin
               w_next    = ST_DONE;
               w_set_err = 1'b1;
            end
         end
         ST_HDR_DISPATCH: begin
            if (!i_controller_en) begin
               w_next    = ST_HDR_EXIT;
               w_set_err = 1'b1;
            end else if (i_cp_interface) begin
               w_next = ST_CCC;
            end else begin
               w_next = ST_DDR;
            end
         end
         ST_CCC, ST_DDR: begin
            w_set_abort = !i_controller_en;
            if (w_hdr_phase_done) begin
               if (!i_controller_en || r_abort) begin
                  w_next    = ST_HDR_EXIT;
                  w_set_err = 1'b1;
               end else if (i_toc_interface) begin
                  w_next = ST_HDR_EXIT;
               end else begin
                  w_next = ST_HDR_RESTART;
               end
            end else if (w_expired) begin
               w_next    = ST_HDR_EXIT;
               w_set_err = 1'b1;
            end
         end
         ST_HDR_RESTART: begin
            if (i_restart_done) begin
               w_next = ST_HDR_DISPATCH;
            end else if (w_expired) begin
               w_next    = ST_HDR_EXIT;
               w_set_err = 1'b1;
            end
         end
         ST_HDR_EXIT: begin
            if (i_exit_done) begin
               w_next = ST_DONE;
            end else if (w_expired) begin
               w_next    = ST_DONE;
               w_set_err = 1'b1;
            end
         end
         ST_DONE: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   // Enables are high only while the phase persists, so they lag entry by one
   // cycle and drop on the cycle the next phase is entered.
   always_ff @(posedge i_sdr_clk or negedge i_sdr_rst_n) begin
      if (!i_sdr_rst_n) begin
         r_state                <= ST_IDLE;
         r_prev_state           <= ST_IDLE;
         r_hdr_prio             <= 1'b0;
         r_err                  <= 1'b0;
         r_abort                <= 1'b0;
         o_sdr_enable           <= 1'b0;
         o_enthdr_enable        <= 1'b0;
         o_ccc_enable           <= 1'b0;
         o_ddrmode_enable       <= 1'b0;
         o_restart_enable       <= 1'b0;
         o_exit_enable          <= 1'b0;
         o_regf_address_special <= 8'h00;
         o_busy                 <= 1'b0;
         o_ctrl_done            <= 1'b0;
         o_error                <= 1'b0;
      end else begin
         r_state      <= w_next;
         r_prev_state <= r_state;
         if (r_state == ST_IDLE) begin
            r_err   <= w_set_err;
            r_abort <= 1'b0;
         end else begin
            if (w_set_err)   r_err   <= 1'b1;
            if (w_set_abort) r_abort <= 1'b1;
         end
         if (r_state == ST_DONE) begin
            r_hdr_prio <= ~r_hdr_prio;
         end
         o_sdr_enable           <= (r_state == ST_SDR_XFER)    && (w_next == ST_SDR_XFER);
         o_enthdr_enable        <= (r_state == ST_ENTHDR)      && (w_next == ST_ENTHDR);
         o_ccc_enable           <= (r_state == ST_CCC)         && (w_next == ST_CCC);
         o_ddrmode_enable       <= (r_state == ST_DDR)         && (w_next == ST_DDR);
         o_restart_enable       <= (r_state == ST_HDR_RESTART) && (w_next == ST_HDR_RESTART);
         o_exit_enable          <= (r_state == ST_HDR_EXIT)    && (w_next == ST_HDR_EXIT);
         o_regf_address_special <= phase_addr(w_next);
         o_busy                 <= (w_next != ST_IDLE);
         o_ctrl_done            <= (r_state == ST_DONE);
         o_error                <= (r_state == ST_DONE) && r_err;
      end
   end

endmodule

// File: tb/tb_i3c_mode_scheduler.sv
// Directed self-checking bench for i3c_mode_scheduler; every expected value
// below is hand-derived cycle by cycle from the scheduler's behaviour.
module tb_i3c_mode_scheduler;

   localparam logic [7:0] EN_SDR  = 8'h20;
   localparam logic [7:0] EN_ENT  = 8'h10;
   localparam logic [7:0] EN_CCC  = 8'h08;
   localparam logic [7:0] EN_DDR  = 8'h04;
   localparam logic [7:0] EN_RST  = 8'h02;
   localparam logic [7:0] EN_EXIT = 8'h01;
   localparam logic [7:0] ST_BUSY = 8'h04;

   logic       clk = 1'b0;
   logic       rstN;
   logic       ctrlEn;
   logic       sdrReq;
   logic       hdrReq;
   logic       toc;
   logic       cp;
   logic [2:0] mode;
   logic [5:0] doneVec;
   logic       oSdrEn, oEntEn, oCccEn, oDdrEn, oRstEn, oExitEn;
   logic [7:0] oAddr;
   logic       oBusy, oCtrlDone, oError;
   logic [7:0] enVec;
   logic [7:0] statVec;
   int         checks = 0;
   int         errors = 0;
   int         hi;

   always #5 clk = ~clk;

   assign enVec   = {2'b00, oSdrEn, oEntEn, oCccEn, oDdrEn, oRstEn, oExitEn};
   assign statVec = {5'b00000, oBusy, oCtrlDone, oError};

   i3c_mode_scheduler #(
      .TIMEOUT_CYCLES(16)
   ) dut (
      .i_sdr_clk              (clk),
      .i_sdr_rst_n            (rstN),
      .i_controller_en        (ctrlEn),
      .i_sdr_req              (sdrReq),
      .i_hdr_req              (hdrReq),
      .i_toc_interface        (toc),
      .i_cp_interface         (cp),
      .i_MODE_interface       (mode),
      .i_sdr_done             (doneVec[5]),
      .i_enthdr_done          (doneVec[4]),
      .i_ccc_done             (doneVec[3]),
      .i_ddr_mode_done        (doneVec[2]),
      .i_restart_done         (doneVec[1]),
      .i_exit_done            (doneVec[0]),
      .o_sdr_enable           (oSdrEn),
      .o_enthdr_enable        (oEntEn),
      .o_ccc_enable           (oCccEn),
      .o_ddrmode_enable       (oDdrEn),
      .o_restart_enable       (oRstEn),
      .o_exit_enable          (oExitEn),
      .o_regf_address_special (oAddr),
      .o_busy                 (oBusy),
      .o_ctrl_done            (oCtrlDone),
      .o_error                (oError)
   );

   task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %02h expected %02h at %0t", tag, actual, expected, $time);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic applyStimulus(input logic en, input logic sReq, input logic hReq,
                                input logic [2:0] md, input logic cpIn, input logic tocIn);
      ctrlEn = en;
      sdrReq = sReq;
      hdrReq = hReq;
      mode   = md;
      cp     = cpIn;
      toc    = tocIn;
   endtask

   // Called on the negedge right after a phase is entered; returns on the
   // negedge right after the following phase is entered.
   task automatic runPhase(input string tag, input logic [7:0] expEn, input logic [7:0] expAddr);
      checkOutput({tag, " entry en"}, enVec, 8'h00);
      checkOutput({tag, " entry addr"}, oAddr, expAddr);
      step();
      checkOutput({tag, " en"}, enVec, expEn);
      checkOutput({tag, " addr"}, oAddr, expAddr);
      doneVec = expEn[5:0];
      step();
      doneVec = 6'b000000;
      checkOutput({tag, " en drop"}, enVec, 8'h00);
   endtask

   task automatic dispatch(input string tag);
      checkOutput({tag, " dispatch addr"}, oAddr, 8'h00);
      checkOutput({tag, " dispatch stat"}, statVec, ST_BUSY);
      step();
   endtask

   task automatic expectDone(input string tag, input logic expErr);
      checkOutput({tag, " done entry"}, statVec, ST_BUSY);
      step();
      checkOutput({tag, " done pulse"}, statVec, {6'b000000, 1'b1, expErr});
      checkOutput({tag, " done en"}, enVec, 8'h00);
      sdrReq = 1'b0;
      hdrReq = 1'b0;
      step();
      checkOutput({tag, " back idle"}, statVec, 8'h00);
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL global time limit expired");
      $fatal(1, "[TB] stuck");
   end

   initial begin
      rstN    = 1'b0;
      doneVec = 6'b000000;
      applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
      repeat (3) step();
      checkOutput("reset en", enVec, 8'h00);
      checkOutput("reset addr", oAddr, 8'h00);
      checkOutput("reset stat", statVec, 8'h00);
      rstN = 1'b1;
      step();

      // Requests ignored while the controller is disabled
      applyStimulus(1'b0, 1'b1, 1'b1, 3'd6, 1'b0, 1'b1);
      repeat (3) step();
      checkOutput("disabled en", enVec, 8'h00);
      checkOutput("disabled stat", statVec, 8'h00);
      applyStimulus(1'b1, 1'b0, 1'b0, 3'd6, 1'b0, 1'b1);
      step();

      // Plain SDR transfer with a stray CCC done that must be ignored
      applyStimulus(1'b1, 1'b1, 1'b0, 3'd6, 1'b0, 1'b1);
      step();
      checkOutput("sdr enable lag", enVec, 8'h00);
      checkOutput("sdr busy", statVec, ST_BUSY);
      doneVec = 6'b001000;
      step();
      doneVec = 6'b000000;
      checkOutput("sdr en", enVec, EN_SDR);
      step();
      checkOutput("sdr stray done ignored", enVec, EN_SDR);
      doneVec = 6'b100000;
      step();
      doneVec = 6'b000000;
      checkOutput("sdr en drop", enVec, 8'h00);
      expectDone("sdr", 1'b0);

      // HDR-DDR transfer followed by exit
      applyStimulus(1'b1, 1'b0, 1'b1, 3'd6, 1'b0, 1'b1);
      step();
      runPhase("ddr-exit enthdr", EN_ENT, 8'h2E);
      dispatch("ddr-exit");
      runPhase("ddr-exit ddr", EN_DDR, 8'h31);
      runPhase("ddr-exit exit", EN_EXIT, 8'h00);
      expectDone("ddr-exit", 1'b0);

      // DDR, restart, then CCC and exit
      applyStimulus(1'b1, 1'b0, 1'b1, 3'd6, 1'b0, 1'b0);
      step();
      runPhase("restart enthdr", EN_ENT, 8'h2E);
      dispatch("restart 1");
      runPhase("restart ddr", EN_DDR, 8'h31);
      applyStimulus(1'b1, 1'b0, 1'b1, 3'd6, 1'b1, 1'b1);
      runPhase("restart restart", EN_RST, 8'h00);
      dispatch("restart 2");
      runPhase("restart ccc", EN_CCC, 8'h30);
      runPhase("restart exit", EN_EXIT, 8'h00);
      expectDone("restart", 1'b0);

      // Controller disabled during dispatch forces exit with error
      applyStimulus(1'b1, 1'b0, 1'b1, 3'd6, 1'b0, 1'b1);
      step();
      runPhase("dis-dispatch enthdr", EN_ENT, 8'h2E);
      ctrlEn = 1'b0;
      dispatch("dis-dispatch");
      runPhase("dis-dispatch exit", EN_EXIT, 8'h00);
      expectDone("dis-dispatch", 1'b1);

      // Controller disabled in CCC overrides toc=0 once the CCC completes
      applyStimulus(1'b1, 1'b0, 1'b1, 3'd6, 1'b1, 1'b0);
      step();
      runPhase("dis-ccc enthdr", EN_ENT, 8'h2E);
      dispatch("dis-ccc");
      ctrlEn = 1'b0;
      runPhase("dis-ccc ccc", EN_CCC, 8'h30);
      runPhase("dis-ccc exit", EN_EXIT, 8'h00);
      expectDone("dis-ccc", 1'b1);

      // Illegal HDR mode completes at once with error and no engine
      applyStimulus(1'b1, 1'b0, 1'b1, 3'd3, 1'b0, 1'b1);
      step();
      checkOutput("bad mode en", enVec, 8'h00);
      checkOutput("bad mode addr", oAddr, 8'h00);
      expectDone("bad mode", 1'b1);

      // SDR phase watchdog expiry
      applyStimulus(1'b1, 1'b1, 1'b0, 3'd6, 1'b0, 1'b1);
      step();
      repeat (16) step();
      checkOutput("sdr timeout last en", enVec, EN_SDR);
      step();
      checkOutput("sdr timeout en drop", enVec, 8'h00);
      expectDone("sdr timeout", 1'b1);

      // Done arriving on the expiry cycle wins without error
      applyStimulus(1'b1, 1'b1, 1'b0, 3'd6, 1'b0, 1'b1);
      step();
      repeat (16) step();
      checkOutput("sdr race en", enVec, EN_SDR);
      doneVec = 6'b100000;
      step();
      doneVec = 6'b000000;
      expectDone("sdr race", 1'b0);

      // DDR watchdog expiry leads through exit to an error completion
      applyStimulus(1'b1, 1'b0, 1'b1, 3'd6, 1'b0, 1'b1);
      step();
      runPhase("ddr timeout enthdr", EN_ENT, 8'h2E);
      dispatch("ddr timeout");
      step();
      hi = 0;
      while (enVec == EN_DDR && hi < 40) begin
         hi++;
         step();
      end
      checkOutput("ddr timeout length", hi[7:0], 8'd16);
      runPhase("ddr timeout exit", EN_EXIT, 8'h00);
      expectDone("ddr timeout", 1'b1);

      // Asynchronous reset in the middle of DDR
      applyStimulus(1'b1, 1'b0, 1'b1, 3'd6, 1'b0, 1'b1);
      step();
      runPhase("reset-ddr enthdr", EN_ENT, 8'h2E);
      dispatch("reset-ddr");
      step();
      checkOutput("reset-ddr en before", enVec, EN_DDR);
      #2 rstN = 1'b0;
      #1;
      checkOutput("reset-ddr async en", enVec, 8'h00);
      checkOutput("reset-ddr async addr", oAddr, 8'h00);
      checkOutput("reset-ddr async stat", statVec, 8'h00);
      hdrReq = 1'b0;
      step();
      rstN = 1'b1;
      step();
      checkOutput("reset-ddr after en", enVec, 8'h00);
      checkOutput("reset-ddr after stat", statVec, 8'h00);
      step();
      checkOutput("reset-ddr no done", statVec, 8'h00);

      // Simultaneous requests twice: SDR first after reset, then HDR
      applyStimulus(1'b1, 1'b1, 1'b1, 3'd6, 1'b0, 1'b1);
      step();
      runPhase("rr first sdr", EN_SDR, 8'h00);
      expectDone("rr first", 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b1, 3'd6, 1'b0, 1'b1);
      step();
      runPhase("rr second enthdr", EN_ENT, 8'h2E);
      dispatch("rr second");
      runPhase("rr second ddr", EN_DDR, 8'h31);
      runPhase("rr second exit", EN_EXIT, 8'h00);
      expectDone("rr second", 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
